// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR bank.
// DEF_TAPS16 default tap mask, config select codes, out_data slice index.
package lfsr_pkg;

    localparam logic [15:0] DEF_TAPS16 = 16'hB400;

    localparam logic CFG_SEL_TAPS = 1'b0;
    localparam logic CFG_SEL_SEED = 1'b1;

    function automatic int slice_lo(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational STEPS-shift Fibonacci LFSR next-state function.
// Ports: state_i, taps_i (WIDTH) in; next_o (WIDTH) out.
module lfsr_step #(
    parameter int WIDTH = 16,
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] taps_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = state_i;
        for (int i = 0; i < STEPS; i++) begin
            next_o = {next_o[WIDTH-2:0], ^(next_o & taps_i)};
        end
    end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NCHAN programmable Fibonacci LFSRs with a valid/ready output register.
// Ports: clk, reset (sync, high), run, cfg_we/cfg_chan/cfg_sel/cfg_data,
// out_valid/out_ready/out_data, lockup. Macro LFSR_LOCKUP_RECOVER_EN enables
// all-zero recovery; without it lockup is tied low.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCHAN = 4,
    parameter int STEPS = 1,
    parameter logic [WIDTH-1:0] DEF_TAPS = WIDTH'(DEF_TAPS16),
    parameter logic [WIDTH-1:0] DEF_SEED = WIDTH'(1),
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   cfg_we,
    input  logic [CW-1:0]          cfg_chan,
    input  logic                   cfg_sel,
    input  logic [WIDTH-1:0]       cfg_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCHAN*WIDTH-1:0] out_data,
    output logic [NCHAN-1:0]       lockup
);

    logic [WIDTH-1:0] state_q [NCHAN];
    logic [WIDTH-1:0] state_d [NCHAN];
    logic [WIDTH-1:0] taps_q  [NCHAN];
    logic [WIDTH-1:0] taps_d  [NCHAN];
    logic [WIDTH-1:0] seed_q  [NCHAN];
    logic [WIDTH-1:0] seed_d  [NCHAN];
    logic [WIDTH-1:0] shift_nxt [NCHAN];
    logic [WIDTH-1:0] adv_nxt [NCHAN];

    logic [NCHAN-1:0] seed_hit;
    logic [NCHAN-1:0] taps_hit;

    logic                   out_valid_q, out_valid_d;
    logic [NCHAN*WIDTH-1:0] out_data_q, out_data_d;
    logic                   advance;

    assign advance = run && (!out_valid_q || out_ready);

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic [NCHAN-1:0] zero_st;
    logic [NCHAN-1:0] lockup_q, lockup_d;
`endif

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        lfsr_step #(
            .WIDTH (WIDTH),
            .STEPS (STEPS)
        ) u_step (
            .state_i (state_q[c]),
            .taps_i  (taps_q[c]),
            .next_o  (shift_nxt[c])
        );

        // Out-of-range channel numbers match no channel and are dropped.
        assign seed_hit[c] = cfg_we && (cfg_chan == CW'(c))
                             && (cfg_sel == CFG_SEL_SEED);
        assign taps_hit[c] = cfg_we && (cfg_chan == CW'(c))
                             && (cfg_sel == CFG_SEL_TAPS);

`ifdef LFSR_LOCKUP_RECOVER_EN
        // A stuck channel reloads its seed; a zero seed would stay stuck,
        // so it falls back to 1.
        assign zero_st[c] = (state_q[c] == '0);
        assign adv_nxt[c] = !zero_st[c] ? shift_nxt[c] :
                            (seed_q[c] == '0) ? WIDTH'(1) : seed_q[c];
`else
        assign adv_nxt[c] = shift_nxt[c];
`endif
    end

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        seed_d      = seed_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (advance) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        for (int c = 0; c < NCHAN; c++) begin
            if (advance) begin
                state_d[c] = adv_nxt[c];
            end
            // Seed load wins over the advance on the same channel.
            if (seed_hit[c]) begin
                state_d[c] = cfg_data;
                seed_d[c]  = cfg_data;
            end
            if (taps_hit[c]) begin
                taps_d[c] = cfg_data;
            end
            if (advance) begin
                out_data_d[slice_lo(c, WIDTH) +: WIDTH] = state_d[c];
            end
        end
    end

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign lockup_d = advance ? (zero_st & ~seed_hit) : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                state_q[c] <= DEF_SEED;
                seed_q[c]  <= DEF_SEED;
                taps_q[c]  <= DEF_TAPS;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            taps_q      <= taps_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup_q    <= lockup_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign lockup = lockup_q;
`else
    assign lockup = '0;
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Randomized self-checking bench for lfsr_bank against an arithmetic model.
// Instance A: 16b x 4 ch, STEPS=1. Instance B: 16b x 3 ch, STEPS=4.
module tb_lfsr_bank;

    logic        clk = 1'b0;
    logic        reset, run, cfg_we, cfg_sel, out_ready;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_data;

    logic        va, vb;
    logic [63:0] da;
    logic [47:0] db;
    logic [3:0]  la;
    logic [2:0]  lb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_bank #(.WIDTH(16), .NCHAN(4), .STEPS(1)) dut_a (
        .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we),
        .cfg_chan(cfg_chan), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .out_valid(va), .out_ready(out_ready), .out_data(da),
        .lockup(la)
    );

    lfsr_bank #(.WIDTH(16), .NCHAN(3), .STEPS(4)) dut_b (
        .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we),
        .cfg_chan(cfg_chan), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .out_valid(vb), .out_ready(out_ready), .out_data(db),
        .lockup(lb)
    );

    // Reference model: plain integers, one row per instance.
    int unsigned m_st   [2][4];
    int unsigned m_tap  [2][4];
    int unsigned m_seed [2][4];
    int unsigned m_dat  [2][4];
    bit          m_lk   [2][4];
    bit          m_v    [2];
    int          nch    [2] = '{4, 3};
    int          nst    [2] = '{1, 4};

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned shift1(input int unsigned s,
                                           input int unsigned t);
        int unsigned fb;
        fb = $countones(s & t) % 2;
        return ((s * 2) + fb) % 65536;
    endfunction

    task automatic model_step();
        bit adv;
        int unsigned ns;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int c = 0; c < 4; c++) begin
                    m_st[k][c] = 1; m_seed[k][c] = 1;
                    m_tap[k][c] = 16'hB400; m_dat[k][c] = 0;
                    m_lk[k][c] = 0;
                end
                m_v[k] = 0;
            end else begin
                adv = run && (!m_v[k] || out_ready);
                for (int c = 0; c < nch[k]; c++) begin
                    m_lk[k][c] = 0;
                    ns = m_st[k][c];
                    if (adv) begin
                        if (RECOVER && ns == 0) begin
                            ns = (m_seed[k][c] == 0) ? 1 : m_seed[k][c];
                            m_lk[k][c] = 1;
                        end else begin
                            for (int s = 0; s < nst[k]; s++)
                                ns = shift1(ns, m_tap[k][c]);
                        end
                    end
                    if (cfg_we && cfg_chan == c) begin
                        if (cfg_sel) begin
                            ns = cfg_data;
                            m_seed[k][c] = cfg_data;
                            m_lk[k][c] = 0;
                        end else begin
                            m_tap[k][c] = cfg_data;
                        end
                    end
                    m_st[k][c] = ns;
                    if (adv) m_dat[k][c] = ns;
                end
                if (adv) m_v[k] = 1;
                else if (out_ready) m_v[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("a_valid", 64'(va), 64'(m_v[0]));
        check("b_valid", 64'(vb), 64'(m_v[1]));
        for (int c = 0; c < 4; c++) begin
            check($sformatf("a_data%0d", c), 64'(da[c*16 +: 16]),
                  64'(m_dat[0][c]));
            check($sformatf("a_lock%0d", c), 64'(la[c]), 64'(m_lk[0][c]));
        end
        for (int c = 0; c < 3; c++) begin
            check($sformatf("b_data%0d", c), 64'(db[c*16 +: 16]),
                  64'(m_dat[1][c]));
            check($sformatf("b_lock%0d", c), 64'(lb[c]), 64'(m_lk[1][c]));
        end
    endtask

    task automatic cycle(input bit rst, input bit rn, input bit rdy,
                         input bit we, input logic [1:0] ch, input bit sel,
                         input logic [15:0] d);
        @(negedge clk);
        reset = rst; run = rn; out_ready = rdy;
        cfg_we = we; cfg_chan = ch; cfg_sel = sel; cfg_data = d;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    bit          seen [65536];
    int          dups, zeros;
    logic [15:0] held, w, ch1_prev;

    initial begin
        reset = 1; run = 0; out_ready = 0;
        cfg_we = 0; cfg_chan = 0; cfg_sel = 0; cfg_data = 0;

        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        check("rst_valid", 64'(va), 64'd0);
        check("rst_data", da, 64'd0);
        check("rst_lockup", 64'(la), 64'd0);

        // Known start of the default sequence.
        for (int k = 1; k <= 11; k++) begin
            cycle(0, 1, 1, 0, 0, 0, 0);
            check("seq_ch0", 64'(da[15:0]),
                  (k <= 10) ? (64'd1 << k) : 64'h0801);
            if (k == 1) check("steps4_first", 64'(db[15:0]), 64'h0010);
        end

        // Full period on channel 0.
        cycle(1, 0, 0, 0, 0, 0, 0);
        dups = 0; zeros = 0;
        for (int i = 0; i < 65536; i++) seen[i] = 0;
        for (int i = 1; i <= 65535; i++) begin
            cycle(0, 1, 1, 0, 0, 0, 0);
            w = da[15:0];
            if (w == 0) zeros++;
            if (seen[w]) dups++;
            seen[w] = 1;
        end
        check("period_dups", 64'(dups), 64'd0);
        check("period_zeros", 64'(zeros), 64'd0);
        check("period_last", 64'(w), 64'h0001);

        // Stall mid-stream.
        cycle(0, 1, 1, 0, 0, 0, 0);
        held = da[15:0];
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            check("stall_hold", 64'(da[15:0]), 64'(held));
        end
        cycle(0, 1, 1, 0, 0, 0, 0);
        check("stall_next", 64'(da[15:0]), 64'(shift1(held, 16'hB400)));

        // Seed write during an advance, then zero taps on ch1.
        cycle(0, 1, 1, 1, 2'd2, 1, 16'h00FF);
        check("seed_ch2", 64'(da[47:32]), 64'h00FF);
        cycle(0, 1, 1, 1, 2'd1, 0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            ch1_prev = da[31:16];
            cycle(0, 1, 1, 0, 0, 0, 0);
            check("taps0_ch1", 64'(da[31:16]), 64'({ch1_prev[14:0], 1'b0}));
        end

        // Zero seed on ch3, then advance.
        cycle(0, 1, 1, 1, 2'd3, 1, 16'h0000);
        check("zero_seed_ch3", 64'(da[63:48]), 64'h0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        check("lock_ch3_data", 64'(da[63:48]), RECOVER ? 64'h1 : 64'h0);
        check("lock_ch3_pulse", 64'(la[3]), RECOVER ? 64'h1 : 64'h0);
        cycle(0, 1, 1, 0, 0, 0, 0);
        check("lock_ch3_clear", 64'(la[3]), 64'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) == 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(9) < 7),
                  ($urandom_range(9) == 0),
                  2'($urandom_range(3)),
                  1'($urandom_range(1)),
                  ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
